// File: rtl/wb_store_buffer.sv
// In-order store buffer between writeback and the dcache write port.
// Writeback pushes stores; the head entry drains over a req/ack handshake.
module wb_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             wb_wr_v,
  input  logic [31:0]      wb_wr_addr,
  input  logic [31:0]      wb_wr_data,
  input  logic [1:0]       wb_wr_size,
  output logic             sb_full,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count,
  output logic             dc_wr_req,
  output logic [31:0]      dc_wr_addr,
  output logic [31:0]      dc_wr_data,
  output logic [1:0]       dc_wr_size,
  input  logic             dc_wr_ack,
  input  logic             mem_rd_v,
  input  logic [31:0]      mem_rd_addr,
  input  logic [1:0]       mem_rd_size,
  output logic             sb_conflict
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [1:0]       size_d [DEPTH];
  logic             push, pop;

  // Address of the last byte touched; sizes 10 and the illegal 11 both span 4 bytes.
  function automatic logic [31:0] last_byte(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'b00:   return a;
      2'b01:   return a + 32'd1;
      default: return a + 32'd3;
    endcase
  endfunction

  // An access spans at most two dwords, so the spans intersect iff some endpoint dword matches.
  function automatic logic dw_overlap(input logic [31:0] a0, input logic [1:0] s0,
                                      input logic [31:0] a1, input logic [1:0] s1);
    logic [31:0] e0, e1;
    e0 = last_byte(a0, s0);
    e1 = last_byte(a1, s1);
    return (a0[31:2] == a1[31:2]) || (a0[31:2] == e1[31:2]) ||
           (e0[31:2] == a1[31:2]) || (e0[31:2] == e1[31:2]);
  endfunction

  assign sb_count  = count_q;
  assign sb_empty  = (count_q == '0);
  assign sb_full   = (count_q == (PTR_W+1)'(DEPTH));
  assign dc_wr_req = !sb_empty;

  assign dc_wr_addr = dc_wr_req ? addr_q[head_q] : '0;
  assign dc_wr_data = dc_wr_req ? data_q[head_q] : '0;
  assign dc_wr_size = dc_wr_req ? size_q[head_q] : '0;

  assign push = wb_wr_v && !sb_full;
  assign pop  = dc_wr_req && dc_wr_ack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    if (pop) begin
      head_d        = head_q + 1'b1;
      vld_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d         = tail_q + 1'b1;
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = wb_wr_addr;
      data_d[tail_q] = wb_wr_data;
      size_d[tail_q] = wb_wr_size;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    sb_conflict = 1'b0;
    if (mem_rd_v) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && dw_overlap(mem_rd_addr, mem_rd_size, addr_q[i], size_q[i]))
          sb_conflict = 1'b1;
      end
      if (push && dw_overlap(mem_rd_addr, mem_rd_size, wb_wr_addr, wb_wr_size))
        sb_conflict = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload is only observed through valid entries, so it carries no reset.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

endmodule

// File: tb/tb_wb_store_buffer.sv
// Self-checking bench for wb_store_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             wb_wr_v;
  logic [31:0]      wb_wr_addr, wb_wr_data;
  logic [1:0]       wb_wr_size;
  logic             sb_full, sb_empty;
  logic [PTR_W:0]   sb_count;
  logic             dc_wr_req;
  logic [31:0]      dc_wr_addr, dc_wr_data;
  logic [1:0]       dc_wr_size;
  logic             dc_wr_ack;
  logic             mem_rd_v;
  logic [31:0]      mem_rd_addr;
  logic [1:0]       mem_rd_size;
  logic             sb_conflict;

  wb_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .CLR(CLR),
    .wb_wr_v(wb_wr_v), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .wb_wr_size(wb_wr_size),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_size(dc_wr_size),
    .dc_wr_ack(dc_wr_ack),
    .mem_rd_v(mem_rd_v), .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size),
    .sb_conflict(sb_conflict)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t         model_q[$];
  logic [31:0] popped_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        last_conflict;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  // Byte-by-byte comparison of the dwords touched by two accesses.
  function automatic logic overlaps(input logic [31:0] a0, input logic [1:0] s0,
                                    input logic [31:0] a1, input logic [1:0] s1);
    logic [31:0] x, y;
    for (int i = 0; i < nbytes(s0); i++) begin
      for (int j = 0; j < nbytes(s1); j++) begin
        x = a0 + 32'(i);
        y = a1 + 32'(j);
        if (x[31:2] == y[31:2]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive, check against the model mid-cycle, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [1:0] ws, input logic ack,
                       input logic rv, input logic [31:0] ra, input logic [1:0] rs);
    int   n;
    logic do_push, do_pop, exp_cf;
    st_t  e;
    wb_wr_v = v; wb_wr_addr = wa; wb_wr_data = wd; wb_wr_size = ws;
    dc_wr_ack = ack; mem_rd_v = rv; mem_rd_addr = ra; mem_rd_size = rs;
    @(negedge CLK);
    n = model_q.size();
    do_push = v && (n < DEPTH);
    do_pop  = (n > 0) && ack;
    chk("count", 64'(sb_count), 64'(n));
    chk("empty", 64'(sb_empty), 64'(n == 0));
    chk("full",  64'(sb_full),  64'(n == DEPTH));
    chk("req",   64'(dc_wr_req), 64'(n > 0));
    if (n > 0) begin
      chk("head_addr", 64'(dc_wr_addr), 64'(model_q[0].addr));
      chk("head_data", 64'(dc_wr_data), 64'(model_q[0].data));
      chk("head_size", 64'(dc_wr_size), 64'(model_q[0].size));
    end
    exp_cf = 1'b0;
    if (rv) begin
      foreach (model_q[k]) if (overlaps(ra, rs, model_q[k].addr, model_q[k].size)) exp_cf = 1'b1;
      if (do_push && overlaps(ra, rs, wa, ws)) exp_cf = 1'b1;
    end
    chk("conflict", 64'(sb_conflict), 64'(exp_cf));
    last_conflict = sb_conflict;
    if (do_pop) popped_q.push_back(dc_wr_addr);
    @(posedge CLK);
    #1;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.addr = wa; e.data = wd; e.size = ws;
      model_q.push_back(e);
    end
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, ack, 1'b0, 32'h0, 2'b00);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [1:0] s, input logic ack);
    cycle(1'b1, a, $urandom, s, ack, 1'b0, 32'h0, 2'b00);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      1:       return 32'($urandom_range(0, 7));
      default: return 32'h100 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1'b0;
    wb_wr_v = 0; wb_wr_addr = 0; wb_wr_data = 0; wb_wr_size = 0;
    dc_wr_ack = 0; mem_rd_v = 0; mem_rd_addr = 0; mem_rd_size = 0;
    #3;
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_full",  64'(sb_full),  64'd0);
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_req",   64'(dc_wr_req), 64'd0);
    chk("rst_cf",    64'(sb_conflict), 64'd0);
    chk("rst_addr",  64'(dc_wr_addr), 64'd0);
    chk("rst_data",  64'(dc_wr_data), 64'd0);
    chk("rst_size",  64'(dc_wr_size), 64'd0);
    @(posedge CLK);
    #2 CLR = 1'b1;

    // Single store: no bypass, visible the cycle after the push edge.
    cycle(1'b1, 32'h2004, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 32'h0, 2'b00);
    chk("lat_req_c1",  64'(dc_wr_req), 64'd1);
    chk("lat_data_c1", 64'(dc_wr_data), 64'h1234_5678);
    idle(1'b0);
    chk("lat_addr_c2", 64'(dc_wr_addr), 64'h2004);
    idle(1'b1);
    chk("lat_cnt",   64'(sb_count), 64'd0);
    chk("lat_empty", 64'(sb_empty), 64'd1);

    // Fill, refuse while full, drain in order with tail wrap.
    popped_q.delete();
    for (int k = 1; k <= 4; k++) push_st(32'(k * 16), 2'b10, 1'b0);
    chk("fill_full", 64'(sb_full), 64'd1);
    chk("fill_cnt",  64'(sb_count), 64'd4);
    push_st(32'h50, 2'b10, 1'b0);
    chk("fill_reject_cnt", 64'(sb_count), 64'd4);
    push_st(32'h50, 2'b10, 1'b1);
    chk("fill_pop_only", 64'(sb_count), 64'd3);
    push_st(32'h50, 2'b10, 1'b1);
    push_st(32'h60, 2'b10, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk("drain_n", 64'(popped_q.size()), 64'd6);
    foreach (popped_q[k]) chk("drain_order", 64'(popped_q[k]), 64'((k + 1) * 16));

    // Full with pop: push refused this cycle, accepted the next.
    for (int k = 0; k < 4; k++) push_st(32'h200 + 32'(k * 4), 2'b00, 1'b0);
    cycle(1'b1, 32'h70, 32'hCAFE_0070, 2'b01, 1'b1, 1'b0, 32'h0, 2'b00);
    chk("fullpop_cnt3", 64'(sb_count), 64'd3);
    cycle(1'b1, 32'h70, 32'hCAFE_0070, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
    chk("fullpop_cnt4", 64'(sb_count), 64'd4);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Simultaneous push and pop at count 2.
    push_st(32'hA0, 2'b10, 1'b0);
    push_st(32'hB0, 2'b10, 1'b0);
    push_st(32'hC0, 2'b10, 1'b1);
    chk("pp_cnt",  64'(sb_count), 64'd2);
    chk("pp_head", 64'(dc_wr_addr), 64'hB0);
    idle(1'b1);
    idle(1'b1);

    // Load/store overlap across a dword boundary.
    cycle(1'b1, 32'h1003, 32'h5555_AAAA, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h1004, 2'b00);
    chk("cf_cross", 64'(last_conflict), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h1008, 2'b10);
    chk("cf_clear", 64'(last_conflict), 64'd0);
    cycle(1'b1, 32'h100A, 32'h77, 2'b00, 1'b0, 1'b1, 32'h1008, 2'b10);
    chk("cf_incoming", 64'(last_conflict), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h1004, 2'b00);
    chk("cf_rdv0", 64'(last_conflict), 64'd0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset with a request outstanding.
    cycle(1'b1, 32'h1000, 32'hAABB_CCDD, 2'b10, 1'b0, 1'b0, 32'h0, 2'b00);
    idle(1'b0);
    #2 CLR = 1'b0;
    #1;
    chk("arst_req",   64'(dc_wr_req), 64'd0);
    chk("arst_count", 64'(sb_count), 64'd0);
    chk("arst_empty", 64'(sb_empty), 64'd1);
    model_q.delete();
    #1 CLR = 1'b1;
    @(posedge CLK);
    #1;
    idle(1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 55), rand_addr(), $urandom, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 60), rand_addr(), 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
